// File: rtl/delay_scan_ctrl.sv
// delay_scan_ctrl: steps a DRP delay stage across a tap range and reports,
// per tap, the commanded tap, the readback tap and the ones count of the delayed data.
module delay_scan_ctrl #(
    parameter int TAP_W       = 9,
    parameter int CNT_W       = 16,
    parameter int SETTLE_CYC  = 8,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [TAP_W-1:0] cfg_start_tap,
    input  logic [TAP_W-1:0] cfg_end_tap,
    input  logic [TAP_W-1:0] cfg_step,
    input  logic [CNT_W-1:0] cfg_samples,
    output logic             drp_change,
    output logic             drp_read,
    output logic [TAP_W-1:0] drp_delay,
    input  logic             drp_done,
    input  logic [TAP_W-1:0] drp_delay_rb,
    input  logic             sample_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [TAP_W-1:0] res_tap,
    output logic [TAP_W-1:0] res_rb,
    output logic [CNT_W-1:0] res_ones,
    output logic             busy,
    output logic             sweep_done,
    output logic             err_timeout,
    output logic             err_cfg
);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, SETTLE, SAMPLE, REPORT, NEXT, FINISH} state_t;

    state_t           state;
    logic [TAP_W-1:0] tap, end_tap, step;
    logic [CNT_W-1:0] samples, cnt, ones_inc;
    logic [TMO_W-1:0] tmo;
    logic [TAP_W:0]   sum;

    // one extra bit so a step past the top of the tap range ends the sweep
    assign sum      = {1'b0, tap} + {1'b0, step};
    assign ones_inc = (&res_ones) ? res_ones : res_ones + CNT_W'(sample_in);
    assign drp_read = 1'b0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            tap         <= '0;
            end_tap     <= '0;
            step        <= '0;
            samples     <= '0;
            cnt         <= '0;
            tmo         <= '0;
            drp_change  <= 1'b0;
            drp_delay   <= '0;
            res_valid   <= 1'b0;
            res_tap     <= '0;
            res_rb      <= '0;
            res_ones    <= '0;
            busy        <= 1'b0;
            sweep_done  <= 1'b0;
            err_timeout <= 1'b0;
            err_cfg     <= 1'b0;
        end else begin
            drp_change <= 1'b0;
            sweep_done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (cfg_end_tap < cfg_start_tap) begin
                        err_cfg <= 1'b1;
                    end else begin
                        err_cfg     <= 1'b0;
                        err_timeout <= 1'b0;
                        tap         <= cfg_start_tap;
                        drp_delay   <= cfg_start_tap;
                        drp_change  <= 1'b1;
                        end_tap     <= cfg_end_tap;
                        step        <= (cfg_step == '0) ? TAP_W'(1) : cfg_step;
                        samples     <= (cfg_samples == '0) ? CNT_W'(1) : cfg_samples;
                        busy        <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    tmo   <= '0;
                    state <= WAIT_DONE;
                end
                // done takes priority over a timeout landing in the same cycle
                WAIT_DONE: if (drp_done) begin
                    res_rb <= drp_delay_rb;
                    cnt    <= '0;
                    state  <= SETTLE;
                end else if (tmo == TMO_W'(TIMEOUT_CYC - 1)) begin
                    err_timeout <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end else begin
                    tmo <= tmo + TMO_W'(1);
                end
                SETTLE: if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
                    cnt      <= '0;
                    res_ones <= '0;
                    state    <= SAMPLE;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
                SAMPLE: begin
                    res_ones <= ones_inc;
                    cnt      <= cnt + CNT_W'(1);
                    if (cnt == samples - CNT_W'(1)) begin
                        res_tap   <= tap;
                        res_valid <= 1'b1;
                        state     <= REPORT;
                    end
                end
                REPORT: if (res_ready) begin
                    res_valid <= 1'b0;
                    state     <= NEXT;
                end
                NEXT: if (abort || sum > {1'b0, end_tap}) begin
                    sweep_done <= 1'b1;
                    state      <= FINISH;
                end else begin
                    tap        <= sum[TAP_W-1:0];
                    drp_delay  <= sum[TAP_W-1:0];
                    drp_change <= 1'b1;
                    state      <= ISSUE;
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_delay_scan_ctrl.sv
// tb_delay_scan_ctrl: randomized sweeps against a tap-list and sample-window reference model,
// with a behavioural delay stage that answers change requests after a programmable latency.
module tb_delay_scan_ctrl;
    localparam int TAP_W = 9;
    localparam int CNT_W = 16;
    localparam int S     = 8;
    localparam int TMO   = 1023;

    logic             clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic [TAP_W-1:0] cfg_start_tap = '0, cfg_end_tap = '0, cfg_step = '0;
    logic [CNT_W-1:0] cfg_samples = '0;
    logic             drp_change, drp_read, drp_done = 1'b0, sample_in = 1'b0;
    logic [TAP_W-1:0] drp_delay, drp_delay_rb = '0, res_tap, res_rb;
    logic             res_valid, res_ready = 1'b1, busy, sweep_done, err_timeout, err_cfg;
    logic [CNT_W-1:0] res_ones;

    delay_scan_ctrl #(.TAP_W(TAP_W), .CNT_W(CNT_W), .SETTLE_CYC(S), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_start_tap(cfg_start_tap), .cfg_end_tap(cfg_end_tap), .cfg_step(cfg_step),
        .cfg_samples(cfg_samples), .drp_change(drp_change), .drp_read(drp_read),
        .drp_delay(drp_delay), .drp_done(drp_done), .drp_delay_rb(drp_delay_rb),
        .sample_in(sample_in), .res_valid(res_valid), .res_ready(res_ready),
        .res_tap(res_tap), .res_rb(res_rb), .res_ones(res_ones), .busy(busy),
        .sweep_done(sweep_done), .err_timeout(err_timeout), .err_cfg(err_cfg)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0, done_at = -1, done_cyc = -1000000, lat = 3, no_done = 0;
    int sample_mode = 0, ready_mode = 0, stall_left = 0, abort_tap = -1, eff_n = 1;
    int cur_ones = 0, chg_idx = 0, rec_idx = 0, sd_cnt = 0, tmo_cyc = -1, chg_cyc = 0, last_tap = -1;
    int exp_taps[$];
    logic [TAP_W-1:0] rb_next = '0, cur_rb = '0, prev_tap = '0, prev_rb = '0;
    logic [CNT_W-1:0] prev_ones = '0;
    logic             prev_valid = 1'b0, prev_hs = 1'b0;

    task automatic chk(string tag, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // one clock: observe DUT, model the delay stage and the consumer, drive next inputs
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (drp_change) begin
            if (chg_idx < exp_taps.size()) chk("chg_tap", drp_delay, exp_taps[chg_idx]);
            else chk("chg_extra", chg_idx, exp_taps.size());
            chk("chg_in_rpt", res_valid, 0);
            chg_idx++;
            chg_cyc  = cyc;
            last_tap = drp_delay;
            done_at  = no_done ? -1 : cyc + lat;
            rb_next  = TAP_W'($urandom);
        end
        drp_done     = (cyc == done_at);
        drp_delay_rb = rb_next;
        if (drp_done) begin
            done_cyc = cyc;
            cur_rb   = rb_next;
            cur_ones = 0;
        end
        if (abort_tap >= 0 && last_tap == abort_tap && cyc == done_cyc + S + 1) abort = 1'b1;
        sample_in = sample_mode ? 1'b1 : 1'($urandom);
        if (cyc > done_cyc + S && cyc <= done_cyc + S + eff_n) cur_ones += int'(sample_in);
        if (stall_left > 0) begin
            res_ready = 1'b0;
            if (res_valid) stall_left--;
        end else begin
            res_ready = ready_mode ? 1'($urandom) : 1'b1;
        end
        if (res_valid && !prev_valid) chk("rep_lat", cyc - done_cyc, S + eff_n + 1);
        if (prev_valid && !prev_hs) begin
            chk("valid_hold", res_valid, 1);
            chk("tap_hold", res_tap, prev_tap);
            chk("rb_hold", res_rb, prev_rb);
            chk("ones_hold", res_ones, prev_ones);
        end
        if (res_valid && res_ready) begin
            if (rec_idx < exp_taps.size()) chk("rec_tap", res_tap, exp_taps[rec_idx]);
            else chk("rec_extra", rec_idx, exp_taps.size());
            chk("rec_rb", res_rb, cur_rb);
            chk("rec_ones", res_ones, cur_ones);
            rec_idx++;
        end
        if (sweep_done) sd_cnt++;
        if (err_timeout && tmo_cyc < 0) tmo_cyc = cyc;
        prev_valid = res_valid;
        prev_hs    = res_valid && res_ready;
        prev_tap   = res_tap;
        prev_rb    = res_rb;
        prev_ones  = res_ones;
    endtask

    task automatic run_sweep(int st, int en, int stp, int smp, int l, int nd, int ab);
        int s, budget;
        s     = (stp == 0) ? 1 : stp;
        eff_n = (smp == 0) ? 1 : smp;
        exp_taps.delete();
        if (en >= st) begin
            for (int t = st; ; t += s) begin
                exp_taps.push_back(t);
                if (t == ab || nd != 0 || t + s > en) break;
            end
        end
        lat = l; no_done = nd; abort_tap = ab;
        chg_idx = 0; rec_idx = 0; sd_cnt = 0; tmo_cyc = -1;
        cfg_start_tap = TAP_W'(st); cfg_end_tap = TAP_W'(en);
        cfg_step = TAP_W'(stp); cfg_samples = CNT_W'(smp);
        start = 1'b1;
        abort = (ab == st);
        tick();
        start = 1'b0;
        cfg_start_tap = TAP_W'($urandom); cfg_end_tap = TAP_W'($urandom);
        cfg_step = TAP_W'($urandom); cfg_samples = CNT_W'($urandom);
        chk("busy_on", busy, int'(en >= st));
        chk("err_cfg", err_cfg, int'(en < st));
        chk("chg_first", drp_change, int'(en >= st));
        if (en >= st) chk("err_tmo_clr", err_timeout, 0);
        budget = 0;
        while (busy && budget < 20000) begin
            tick();
            budget++;
        end
        chk("sweep_end", int'(budget < 20000), 1);
        repeat (3) tick();
        chk("n_chg", chg_idx, exp_taps.size());
        chk("n_rec", rec_idx, nd ? 0 : exp_taps.size());
        chk("n_done", sd_cnt, (nd != 0 || en < st) ? 0 : 1);
        chk("err_tmo", err_timeout, int'(nd != 0 && en >= st));
        chk("drp_read", drp_read, 0);
        if (nd != 0) chk("tmo_lat", tmo_cyc - chg_cyc, TMO + 1);
        abort = 1'b0;
        abort_tap = -1;
        no_done = 0;
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_ctl", {drp_change, drp_read, res_valid, busy, sweep_done, err_timeout, err_cfg}, 0);
        chk("rst_delay", drp_delay, 0);
        chk("rst_res", {res_tap, res_rb, res_ones}, 0);
        rst_n = 1'b1;
        tick();

        sample_mode = 1;
        run_sweep(0, 4, 2, 4, 3, 0, -1);
        sample_mode = 0;
        run_sweep(3, 5, 1, 5, 2, 0, -1);
        run_sweep(5, 3, 1, 4, 3, 0, -1);
        run_sweep(510, 511, 5, 3, 1, 0, -1);
        run_sweep(510, 511, 0, 0, 2, 0, -1);
        run_sweep(7, 20, 3, 2, 1, 1, -1);
        run_sweep(7, 9, 1, 2, 1, 0, -1);
        stall_left = 20;
        run_sweep(0, 3, 1, 2, 2, 0, -1);
        run_sweep(0, 8, 1, 4, 2, 0, 2);
        run_sweep(10, 20, 2, 2, 1, 0, 10);

        // reset while waiting for done abandons the sweep silently
        exp_taps.delete();
        exp_taps.push_back(5);
        chg_idx = 0; no_done = 1;
        cfg_start_tap = 5; cfg_end_tap = 9; cfg_step = 1; cfg_samples = 3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        chk("mrst_ctl", {drp_change, drp_read, res_valid, busy, sweep_done, err_timeout, err_cfg}, 0);
        chk("mrst_delay", drp_delay, 0);
        chk("mrst_res", {res_tap, res_rb, res_ones}, 0);
        rst_n = 1'b1;
        no_done = 0; done_at = -1; prev_valid = 1'b0;
        tick();
        run_sweep(5, 9, 2, 3, 2, 0, -1);

        ready_mode = 1;
        for (int i = 0; i < 10; i++) begin
            int st, en;
            st = $urandom_range(0, 511);
            en = (i % 4 == 3) ? st - 1 : st + $urandom_range(0, 12);
            if (en > 511) en = 511;
            if (en < 0) en = 0;
            run_sweep(st, en, $urandom_range(0, 4), $urandom_range(0, 20), $urandom_range(1, 5), 0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/delay_scan_ctrl.md
Name: delay_scan_ctrl

Overview:
- Sweep engine directly upstream of the IDELAY3_DRP cascaded delay stage.
- Steps the delay tap from START_TAP to END_TAP by STEP. At each point it issues a change request to the delay stage, waits for done, waits a settle period, then samples the delayed data for a programmed number of cycles.
- Reports one result record per tap: commanded tap, readback count and ones count, through a valid/ready stream.
- Feeds software eye-scan and calibration in the AXI_DELAY IP.

Parameters:
- TAP_W, 9, width of tap value; matches the delay stage delay_in/delay_out.
- CNT_W, 16, width of the sample-count and ones-count fields.
- SETTLE_CYC, 8, clk cycles waited after done before sampling starts (1..255).
- TIMEOUT_CYC, 1023, maximum clk cycles spent waiting for drp_done before declaring a timeout.

Ports:
- clk  in  1  single clock, shared with the delay stage.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begins a sweep when idle.
- abort  in  1  level; stops the sweep at the next safe point.
- cfg_start_tap  in  TAP_W  first tap.
- cfg_end_tap  in  TAP_W  last tap (inclusive).
- cfg_step  in  TAP_W  tap increment; 0 is treated as 1.
- cfg_samples  in  CNT_W  samples per tap; 0 is treated as 1.
- drp_change  out  1  to delay stage change.
- drp_read  out  1  to delay stage read; tied 0 in this block.
- drp_delay  out  TAP_W  to delay stage delay_in.
- drp_done  in  1  from delay stage done.
- drp_delay_rb  in  TAP_W  from delay stage delay_out.
- sample_in  in  1  delayed data, already synchronous to clk.
- res_valid  out  1  result record valid.
- res_ready  in  1  consumer accepts record.
- res_tap  out  TAP_W  commanded tap.
- res_rb  out  TAP_W  readback tap.
- res_ones  out  CNT_W  count of sample_in==1 over the window.
- busy  out  1  high from accept of start until return to IDLE.
- sweep_done  out  1  one-cycle pulse at normal completion.
- err_timeout  out  1  sticky; cleared by the next accepted start.
- err_cfg  out  1  sticky; cleared by the next accepted start.

Behaviour:
- Reset (rst_n=0 at a clk edge) forces every output to 0, the state to IDLE and all counters to 0. Reset applied mid-sweep abandons the sweep; no result is emitted and no error is set.
- Configuration is latched when start is accepted; later cfg changes have no effect on the sweep in progress.
- IDLE: when start=1:
  - If cfg_end_tap < cfg_start_tap, set err_cfg=1 and stay in IDLE.
  - Otherwise clear both errors, set tap=cfg_start_tap, busy=1, and go to ISSUE.
  - start is ignored while busy=1.
- ISSUE:
  - drp_delay is driven with tap from this state onward and held constant until the next ISSUE.
  - drp_change=1 for exactly one cycle; go to WAIT_DONE.
- WAIT_DONE:
  - The timeout counter increments every cycle.
  - drp_done=1: capture drp_delay_rb into res_rb and go to SETTLE.
  - Counter reaches TIMEOUT_CYC without drp_done: set err_timeout=1, busy=0, go to IDLE; no sweep_done.
  - If drp_done and the timeout occur in the same cycle, drp_done wins.
- SETTLE: wait SETTLE_CYC cycles, then go to SAMPLE with ones=0.
- SAMPLE:
  - Runs exactly cfg_samples cycles; ones += sample_in each cycle.
  - ones saturates at all-ones.
  - Then go to REPORT.
- REPORT:
  - res_valid=1, with res_tap/res_rb/res_ones held stable.
  - Stays in REPORT until res_valid and res_ready are both 1 (handshake cycle). res_valid must not drop before that.
  - On handshake go to NEXT.
- NEXT:
  - If abort=1, or tap+cfg_step > cfg_end_tap, or tap+cfg_step overflows TAP_W (computed at TAP_W+1 bits), go to FINISH.
  - Otherwise tap += step and go to ISSUE.
- FINISH: sweep_done=1 for one cycle, busy=0, go to IDLE.
- abort:
  - Sampled only in NEXT, so an in-flight delay change and the pending record always complete.
  - abort held high through a start cycle still lets the sweep run one tap.
- Latency: start to first drp_change is 1 cycle. A tap with a 0-cycle done response takes ≥ 1+1+SETTLE_CYC+cfg_samples cycles to reach res_valid.
- Exactly one drp_change pulse is issued per tap. drp_read stays 0.

Test Plan:
- Sweep with start=0, end=4, step=2, samples=4, sample_in=1, model done 3 cycles after change, res_ready=1 -> 3 records, tap 0/2/4, res_ones=4 each, then one sweep_done pulse and busy=0.
- Sweep with end=5, start=3 and end=3, start=5 -> first gives err_cfg=0 and records 3,4,5; second gives err_cfg=1 with no drp_change and busy stays 0.
- start=510, end=511, step=5 -> single record at tap 510 (overflow stop), then sweep_done. Separately, step=0 -> records 510 and 511.
- Model never asserts done, TIMEOUT_CYC=1023 -> err_timeout=1 exactly 1023 cycles after WAIT_DONE entry, busy=0, no sweep_done; the next start clears err_timeout.
- res_ready held 0 for 20 cycles -> res_valid stays 1 with stable fields, no new drp_change; release -> sweep continues. abort asserted during SAMPLE of tap 2 in a 0..8 sweep -> record for tap 2 is delivered, then sweep_done, no tap 3.
- rst_n=0 for 1 cycle during WAIT_DONE -> all outputs 0 the next cycle, state IDLE; a new start runs a clean sweep.
